// File: rtl/pet_mem_pkg.sv
// Memory-map constants, region encoding and decode result type shared by the
// PET bank controller, its address decoder and the debugger.
package pet_mem_pkg;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        RAM  = 3'd1,
        VRAM = 3'd2,
        ROM  = 3'd3,
        IO   = 3'd4,
        EXP  = 3'd5
    } region_t;

    typedef struct packed {
        region_t     region;
        logic [14:0] ram_addr;
        logic [15:0] exp_addr;
        logic [10:0] vram_addr;
        logic        wp;
    } decode_t;

    localparam logic [15:0] EXP_CTRL_ADDR = 16'hFFF0;

    // Bit positions inside the $FFF0 expansion control register.
    localparam int CTRL_WP_LO     = 0;
    localparam int CTRL_WP_HI     = 1;
    localparam int CTRL_BANK_LO   = 2;
    localparam int CTRL_BANK_HI   = 3;
    localparam int CTRL_RSVD      = 4;
    localparam int CTRL_VRAM_PEEK = 5;
    localparam int CTRL_IO_PEEK   = 6;
    localparam int CTRL_ENABLE    = 7;

    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] ROM_BASE  = 16'h9000;
    localparam logic [15:0] IO_BASE   = 16'hE800;
    localparam logic [15:0] IO_END    = 16'hEFFF;

    function automatic logic in_io(input logic [15:0] a);
        return (a >= IO_BASE) && (a <= IO_END);
    endfunction

    function automatic logic in_vram_window(input logic [15:0] a);
        return (a >= VRAM_BASE) && (a < ROM_BASE);
    endfunction

endpackage

// File: rtl/pet_bank_ctrl_if.sv
// CPU bus and DMA injection port of the PET bank controller.
interface pet_bank_ctrl_if;
    logic        ce_cpu;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        we;
    logic [7:0]  data_out;

    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic        dma_ack;
    logic        dma_sel_ram;

    modport master (
        output ce_cpu, addr, data_in, we, dma_req, dma_addr, dma_we,
        input  data_out, dma_ack, dma_sel_ram
    );

    modport slave (
        input  ce_cpu, addr, data_in, we, dma_req, dma_addr, dma_we,
        output data_out, dma_ack, dma_sel_ram
    );
endinterface

// File: rtl/pet_addr_decode.sv
// Combinational PET address decoder: address plus expansion control register
// to target region, physical addresses and expansion write-protect flag.
module pet_addr_decode
    import pet_mem_pkg::*;
#(
    parameter int RAM_KB  = 32,
    parameter int VRAM_KB = 1,
    parameter bit EXP_EN  = 1'b0
) (
    input  logic [15:0] addr,
    input  logic [7:0]  exp_ctrl,
    output decode_t     dec
);

    localparam logic [16:0] RAM_SIZE  = 17'(RAM_KB * 1024);
    localparam logic [14:0] RAM_MASK  = 15'(RAM_KB * 1024 - 1);
    localparam logic [10:0] VRAM_MASK = 11'(VRAM_KB * 1024 - 1);

    logic override;
    logic high_half;
    logic unused_ctrl_bit;

    assign unused_ctrl_bit = exp_ctrl[CTRL_RSVD];
    assign override        = EXP_EN && exp_ctrl[CTRL_ENABLE] && addr[15];
    assign high_half       = addr[14];

    always_comb begin
        dec.region    = NONE;
        dec.ram_addr  = addr[14:0] & RAM_MASK;
        dec.vram_addr = addr[10:0] & VRAM_MASK;
        // $8000-$BFFF lands in bank 0/1, $C000-$FFFF in bank 2/3.
        dec.exp_addr  = high_half ? {1'b1, exp_ctrl[CTRL_BANK_HI], addr[13:0]}
                                  : {1'b0, exp_ctrl[CTRL_BANK_LO], addr[13:0]};
        dec.wp        = override && (high_half ? exp_ctrl[CTRL_WP_HI]
                                               : exp_ctrl[CTRL_WP_LO]);

        if ({1'b0, addr} < RAM_SIZE) begin
            dec.region = RAM;
        end else if (!addr[15]) begin
            dec.region = NONE;
        end else if (override) begin
            if (exp_ctrl[CTRL_VRAM_PEEK] && in_vram_window(addr)) begin
                dec.region = VRAM;
            end else if (exp_ctrl[CTRL_IO_PEEK] && in_io(addr)) begin
                dec.region = IO;
            end else begin
                dec.region = EXP;
            end
        end else if (in_vram_window(addr)) begin
            dec.region = VRAM;
        end else if (in_io(addr)) begin
            dec.region = IO;
        end else begin
            dec.region = ROM;
        end
    end

endmodule

// File: rtl/pet_bank_ctrl.sv
// PET bank controller: address decode, $FFF0 expansion register, DMA/CPU
// arbitration for the base RAM port and the registered read-data mux.
module pet_bank_ctrl
    import pet_mem_pkg::*;
#(
    parameter int RAM_KB         = 32,
    parameter int VRAM_KB        = 1,
    parameter bit EXP_EN         = 1'b0,
    parameter bit OPEN_BUS_LATCH = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pet_bank_ctrl_if.slave        bus,
    output logic [14:0]           ram_addr,
    output logic                  ram_we,
    output logic [15:0]           exp_addr,
    output logic                  exp_we,
    output logic [10:0]           vram_addr,
    output logic                  vram_we,
    output logic                  io_cs,
    input  logic [7:0]            ram_q,
    input  logic [7:0]            exp_q,
    input  logic [7:0]            vram_q,
    input  logic [7:0]            rom_q,
    input  logic [7:0]            io_q,
    output logic [7:0]            exp_ctrl
);

    decode_t    cpu_dec;
    decode_t    dma_dec;
    logic       cpu_wr;
    logic       ctrl_hit;
    logic       dma_grant;
    logic       dma_busy_q;
    logic       vld_p0;
    region_t    sel_p0;
    logic [7:0] bus_latch_q;
    logic [7:0] rd_mux;
    logic       unused_dma;

    pet_addr_decode #(
        .RAM_KB  (RAM_KB),
        .VRAM_KB (VRAM_KB),
        .EXP_EN  (EXP_EN)
    ) u_cpu_dec (
        .addr     (bus.addr),
        .exp_ctrl (exp_ctrl),
        .dec      (cpu_dec)
    );

    // DMA only ever reaches base RAM, so it sees the unbanked map.
    pet_addr_decode #(
        .RAM_KB  (RAM_KB),
        .VRAM_KB (VRAM_KB),
        .EXP_EN  (EXP_EN)
    ) u_dma_dec (
        .addr     (bus.dma_addr),
        .exp_ctrl (8'h00),
        .dec      (dma_dec)
    );

    assign unused_dma = ^{dma_dec.exp_addr, dma_dec.vram_addr, dma_dec.wp};

    assign cpu_wr   = bus.ce_cpu & bus.we;
    assign ctrl_hit = EXP_EN && (bus.addr == EXP_CTRL_ADDR);

    // dma_busy_q covers the clk after a CPU cycle (sync RAM still returning
    // CPU read data) and the clk after a grant (every-other-clk limit).
    assign dma_grant       = bus.dma_req & ~bus.ce_cpu & ~dma_busy_q;
    assign bus.dma_ack     = dma_grant;
    assign bus.dma_sel_ram = dma_grant;

    always_comb begin
        ram_addr = cpu_dec.ram_addr;
        ram_we   = cpu_wr && (cpu_dec.region == RAM);
        if (dma_grant) begin
            ram_addr = dma_dec.ram_addr;
            ram_we   = bus.dma_we && (dma_dec.region == RAM);
        end
    end

    assign exp_addr  = cpu_dec.exp_addr;
    assign exp_we    = cpu_wr && (cpu_dec.region == EXP) && !cpu_dec.wp && !ctrl_hit;
    assign vram_addr = cpu_dec.vram_addr;
    assign vram_we   = cpu_wr && (cpu_dec.region == VRAM);
    assign io_cs     = bus.ce_cpu && (cpu_dec.region == IO);

    always_comb begin
        rd_mux = OPEN_BUS_LATCH ? bus_latch_q : 8'hFF;
        case (sel_p0)
            RAM:     rd_mux = ram_q;
            VRAM:    rd_mux = vram_q;
            ROM:     rd_mux = rom_q;
            IO:      rd_mux = io_q;
            EXP:     rd_mux = exp_q;
            default: rd_mux = OPEN_BUS_LATCH ? bus_latch_q : 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exp_ctrl     <= 8'h00;
            dma_busy_q   <= 1'b1;
            vld_p0       <= 1'b0;
            sel_p0       <= NONE;
            bus.data_out <= 8'h00;
            bus_latch_q  <= 8'hFF;
        end else begin
            dma_busy_q <= bus.ce_cpu | dma_grant;
            // p0: region of the CPU cycle captured alongside target access
            vld_p0     <= bus.ce_cpu & ~bus.we;
            if (bus.ce_cpu) begin
                sel_p0 <= cpu_dec.region;
            end
            // p1: target data lands in data_out
            if (vld_p0) begin
                bus.data_out <= rd_mux;
                if (sel_p0 != NONE) begin
                    bus_latch_q <= rd_mux;
                end
            end
            if (cpu_wr) begin
                bus_latch_q <= bus.data_in;
            end
            if (cpu_wr && ctrl_hit) begin
                exp_ctrl <= bus.data_in;
            end
        end
    end

endmodule

// File: tb/tb_pet_bank_ctrl.sv
// Directed bench for pet_bank_ctrl with a memory-map level reference model
// compared against the DUT on every clk.
module tb_pet_bank_ctrl;

    localparam int RAM_KB         = 8;
    localparam int VRAM_KB        = 1;
    localparam bit EXP_EN         = 1'b1;
    localparam bit OPEN_BUS_LATCH = 1'b1;

    localparam int RAM_BYTES  = RAM_KB * 1024;
    localparam int VRAM_BYTES = VRAM_KB * 1024;
    localparam logic [7:0] IO_VAL = 8'h3C;

    localparam int T_NONE = 0;
    localparam int T_RAM  = 1;
    localparam int T_VRAM = 2;
    localparam int T_ROM  = 3;
    localparam int T_IO   = 4;
    localparam int T_EXP  = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pet_bank_ctrl_if bus();

    logic [14:0] ram_addr;
    logic        ram_we;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [10:0] vram_addr;
    logic        vram_we;
    logic        io_cs;
    logic [7:0]  ram_q, exp_q, vram_q, rom_q, io_q;
    logic [7:0]  exp_ctrl;

    pet_bank_ctrl #(
        .RAM_KB         (RAM_KB),
        .VRAM_KB        (VRAM_KB),
        .EXP_EN         (EXP_EN),
        .OPEN_BUS_LATCH (OPEN_BUS_LATCH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .exp_addr  (exp_addr),
        .exp_we    (exp_we),
        .vram_addr (vram_addr),
        .vram_we   (vram_we),
        .io_cs     (io_cs),
        .ram_q     (ram_q),
        .exp_q     (exp_q),
        .vram_q    (vram_q),
        .rom_q     (rom_q),
        .io_q      (io_q),
        .exp_ctrl  (exp_ctrl)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[15:8] ^ a[7:0];
    endfunction

    // ---------------- target memories attached to the DUT ----------------
    logic [7:0] t_ram  [0:32767];
    logic [7:0] t_exp  [0:65535];
    logic [7:0] t_vram [0:2047];
    logic [7:0] dma_wdata;

    always @(posedge clk) begin
        ram_q  <= t_ram[ram_addr];
        exp_q  <= t_exp[exp_addr];
        vram_q <= t_vram[vram_addr];
        rom_q  <= rom_byte(bus.addr);
        io_q   <= IO_VAL;
        if (ram_we)  t_ram[ram_addr]   <= bus.dma_sel_ram ? dma_wdata : bus.data_in;
        if (exp_we)  t_exp[exp_addr]   <= bus.data_in;
        if (vram_we) t_vram[vram_addr] <= bus.data_in;
    end

    // ---------------- reference model ----------------
    logic [7:0] m_ram  [0:32767];
    logic [7:0] m_exp  [0:65535];
    logic [7:0] m_vram [0:2047];
    logic [7:0] m_ctrl, m_latch, m_dout, m_rd_val;
    bit         m_busy, m_rd_pend, model_live;
    int         m_rd_tgt;

    function automatic int tgt_of(input logic [15:0] a, input logic [7:0] c);
        if (int'(a) < RAM_BYTES) return T_RAM;
        if (a < 16'h8000) return T_NONE;
        if (EXP_EN && c[7]) begin
            if (c[5] && a < 16'h9000) return T_VRAM;
            if (c[6] && a >= 16'hE800 && a < 16'hF000) return T_IO;
            return T_EXP;
        end
        if (a < 16'h9000) return T_VRAM;
        if (a >= 16'hE800 && a < 16'hF000) return T_IO;
        return T_ROM;
    endfunction

    function automatic int exp_index(input logic [15:0] a, input logic [7:0] c);
        int bank;
        bank = (a >= 16'hC000) ? 2 + int'(c[3]) : int'(c[2]);
        return bank * 16384 + int'(a[13:0]);
    endfunction

    function automatic bit exp_protected(input logic [15:0] a, input logic [7:0] c);
        return (a >= 16'hC000) ? c[1] : c[0];
    endfunction

    function automatic int vram_index(input logic [15:0] a);
        return int'(a) % VRAM_BYTES;
    endfunction

    task automatic model_step();
        int t;
        bit grant;
        logic [15:0] a;
        if (!reset_n) begin
            m_ctrl = 8'h00; m_latch = 8'hFF; m_dout = 8'h00;
            m_busy = 1'b1; m_rd_pend = 1'b0; model_live = 1'b1;
            return;
        end
        a = bus.addr;
        grant = bus.dma_req && !bus.ce_cpu && !m_busy;
        if (m_rd_pend) begin
            m_dout = (m_rd_tgt == T_NONE) ? (OPEN_BUS_LATCH ? m_latch : 8'hFF) : m_rd_val;
            if (m_rd_tgt != T_NONE) m_latch = m_dout;
            m_rd_pend = 1'b0;
        end
        if (bus.ce_cpu) begin
            t = tgt_of(a, m_ctrl);
            if (bus.we) begin
                m_latch = bus.data_in;
                if (t == T_RAM) m_ram[int'(a)] = bus.data_in;
                if (t == T_VRAM) m_vram[vram_index(a)] = bus.data_in;
                if (t == T_EXP && !exp_protected(a, m_ctrl) && a != 16'hFFF0)
                    m_exp[exp_index(a, m_ctrl)] = bus.data_in;
                if (EXP_EN && a == 16'hFFF0) m_ctrl = bus.data_in;
            end else begin
                m_rd_pend = 1'b1;
                m_rd_tgt  = t;
                case (t)
                    T_RAM:   m_rd_val = m_ram[int'(a)];
                    T_VRAM:  m_rd_val = m_vram[vram_index(a)];
                    T_EXP:   m_rd_val = m_exp[exp_index(a, m_ctrl)];
                    T_ROM:   m_rd_val = rom_byte(a);
                    T_IO:    m_rd_val = IO_VAL;
                    default: m_rd_val = 8'h00;
                endcase
            end
        end
        if (grant && bus.dma_we && int'(bus.dma_addr) < RAM_BYTES)
            m_ram[int'(bus.dma_addr)] = dma_wdata;
        m_busy = bus.ce_cpu || grant;
    endtask

    task automatic compare_cycle();
        int t;
        bit grant, ce, wr;
        logic [15:0] a;
        a     = bus.addr;
        ce    = bus.ce_cpu;
        wr    = ce && bus.we;
        grant = bus.dma_req && !ce && !m_busy;
        check("exp_ctrl", exp_ctrl, m_ctrl);
        check("data_out", bus.data_out, m_dout);
        check("dma_ack", bus.dma_ack, grant);
        if (!reset_n) return;
        t = tgt_of(a, m_ctrl);
        check("dma_sel_ram", bus.dma_sel_ram, grant);
        check("ram_we", ram_we, ce ? (wr && t == T_RAM)
                                   : (grant && bus.dma_we && int'(bus.dma_addr) < RAM_BYTES));
        check("exp_we", exp_we, wr && t == T_EXP && !exp_protected(a, m_ctrl) && a != 16'hFFF0);
        check("vram_we", vram_we, wr && t == T_VRAM);
        check("io_cs", io_cs, ce && t == T_IO);
        if (ce && t == T_RAM)  check("ram_addr", ram_addr, a[14:0]);
        if (grant && int'(bus.dma_addr) < RAM_BYTES) check("dma_ram_addr", ram_addr, bus.dma_addr[14:0]);
        if (ce && t == T_EXP)  check("exp_addr", exp_addr, exp_index(a, m_ctrl));
        if (ce && t == T_VRAM) check("vram_addr", vram_addr, vram_index(a));
    endtask

    initial begin
        model_live = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_live) compare_cycle();
        end
    end

    // ---------------- directed stimulus ----------------
    logic       s_ram_we, s_exp_we, s_vram_we;
    logic [15:0] s_exp_addr;
    logic [10:0] s_vram_addr;

    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic w);
        @(posedge clk); #1;
        bus.ce_cpu = 1'b1; bus.addr = a; bus.data_in = d; bus.we = w;
        @(negedge clk);
        s_ram_we = ram_we; s_exp_we = exp_we; s_vram_we = vram_we;
        s_exp_addr = exp_addr; s_vram_addr = vram_addr;
        @(posedge clk); #1;
        bus.ce_cpu = 1'b0; bus.we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, acks;
        bit ack_seen;
        for (int i = 0; i < 32768; i++) begin t_ram[i] = 8'h00; m_ram[i] = 8'h00; end
        for (int i = 0; i < 65536; i++) begin t_exp[i] = 8'h00; m_exp[i] = 8'h00; end
        for (int i = 0; i < 2048; i++)  begin t_vram[i] = 8'h00; m_vram[i] = 8'h00; end
        bus.ce_cpu = 1'b0; bus.we = 1'b0; bus.addr = 16'h0000; bus.data_in = 8'h00;
        bus.dma_req = 1'b0; bus.dma_addr = 16'h0000; bus.dma_we = 1'b0; dma_wdata = 8'h00;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_exp_ctrl", exp_ctrl, 8'h00);
        check("rst_dma_ack", bus.dma_ack, 1'b0);

        // base RAM write then read back
        cpu_cycle(16'h0100, 8'h5A, 1'b1);
        check("t1_ram_we", s_ram_we, 1'b1);
        cpu_cycle(16'h0100, 8'h00, 1'b0);
        check("t1_ram_we_rd", s_ram_we, 1'b0);
        check("t1_read", bus.data_out, 8'h5A);

        // unpopulated $2000 returns the open-bus latch
        cpu_cycle(16'h0200, 8'h33, 1'b1);
        cpu_cycle(16'h0200, 8'h00, 1'b0);
        check("t2_read_0200", bus.data_out, 8'h33);
        cpu_cycle(16'h2000, 8'h5A, 1'b1);
        check("t2_no_ram_we", s_ram_we, 1'b0);
        cpu_cycle(16'h2000, 8'h00, 1'b0);
        check("t2_open_bus", bus.data_out, 8'h5A);

        // expansion enable, high bank write and read-back
        cpu_cycle(16'hFFF0, 8'h80, 1'b1);
        check("t3_ctrl", exp_ctrl, 8'h80);
        check("t3_ctrl_no_exp_we", s_exp_we, 1'b0);
        cpu_cycle(16'hC123, 8'h11, 1'b1);
        check("t3_exp_we", s_exp_we, 1'b1);
        check("t3_exp_addr", s_exp_addr, 16'h8123);
        cpu_cycle(16'hC123, 8'h00, 1'b0);
        check("t3_exp_read", bus.data_out, 8'h11);
        cpu_cycle(16'h8000, 8'h22, 1'b1);
        check("t3_8000_no_vram_we", s_vram_we, 1'b0);
        cpu_cycle(16'h8000, 8'h00, 1'b0);
        check("t3_8000_read", bus.data_out, 8'h22);

        // screen peek-through with high half write-protected
        cpu_cycle(16'hFFF0, 8'hA2, 1'b1);
        cpu_cycle(16'hC000, 8'h99, 1'b1);
        check("t4_wp_exp_we", s_exp_we, 1'b0);
        check("t4_wp_ram_we", s_ram_we, 1'b0);
        check("t4_wp_vram_we", s_vram_we, 1'b0);
        cpu_cycle(16'h8005, 8'h44, 1'b1);
        check("t4_vram_we", s_vram_we, 1'b1);
        check("t4_vram_addr", s_vram_addr, 11'd5);
        cpu_cycle(16'h8805, 8'h00, 1'b0);
        check("t4_vram_mirror", bus.data_out, 8'h44);
        cpu_cycle(16'hC000, 8'h00, 1'b0);
        check("t4_wp_readback", bus.data_out, 8'h00);

        // DMA held while the CPU runs one cycle every 8 clk
        k = 0; acks = 0; ack_seen = 1'b0;
        bus.dma_addr = 16'h0400; dma_wdata = 8'hC0; bus.dma_we = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (ack_seen) begin
                k++;
                bus.dma_addr = 16'h0400 + 16'(k);
                dma_wdata    = 8'hC0 + 8'(k);
            end
            bus.dma_req = 1'b1;
            bus.ce_cpu  = (i % 8 == 0);
            bus.we      = (i % 8 == 0);
            bus.addr    = 16'h0300 + 16'(i / 8);
            bus.data_in = 8'(i / 8 + 1);
            @(negedge clk);
            ack_seen = bus.dma_ack;
            if (ack_seen) acks++;
        end
        @(posedge clk); #1;
        bus.ce_cpu = 1'b0; bus.we = 1'b0; bus.dma_req = 1'b0; bus.dma_we = 1'b0;
        @(negedge clk);
        check("t5_ack_count", acks, 24);
        for (int j = 0; j < 24; j++) check("t5_dma_ram", t_ram[16'h0400 + j], 8'hC0 + 8'(j));
        for (int j = 0; j < 8; j++)  check("t5_cpu_ram", t_ram[16'h0300 + j], 8'(j + 1));

        // reset with everything enabled and DMA pending
        cpu_cycle(16'hFFF0, 8'hFF, 1'b1);
        check("t6_ctrl_ff", exp_ctrl, 8'hFF);
        cpu_cycle(16'hE900, 8'h00, 1'b0);
        check("t6_io_peek", bus.data_out, IO_VAL);
        @(posedge clk); #1;
        bus.dma_req = 1'b1; reset_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_ctrl", exp_ctrl, 8'h00);
        check("t6_rst_ack", bus.dma_ack, 1'b0);
        check("t6_rst_dout", bus.data_out, 8'h00);
        reset_n = 1'b1; bus.dma_req = 1'b0;
        cpu_cycle(16'hF000, 8'h00, 1'b0);
        check("t6_rom_read", bus.data_out, 8'hF0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
